// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: data width, RV32I load/store
// funct3 codes, FSM state encoding and access-size helpers.
// Pure declarations; no logic of its own.
package mem_access_pkg;

    localparam int XLEN = 32;

    // RV32I load funct3 codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // RV32I store funct3 codes
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    // Access width from funct3; unknown codes fall back to a full word.
    function automatic size_e access_size(input logic [2:0] f3, input logic is_store);
        size_e sz;
        sz = SZ_W;
        if (is_store) begin
            case (f3)
                F3_SB:   sz = SZ_B;
                F3_SH:   sz = SZ_H;
                F3_SW:   sz = SZ_W;
                default: sz = SZ_W;
            endcase
        end else begin
            case (f3)
                F3_LB, F3_LBU: sz = SZ_B;
                F3_LH, F3_LHU: sz = SZ_H;
                F3_LW:         sz = SZ_W;
                default:       sz = SZ_W;
            endcase
        end
        return sz;
    endfunction

    // Halfwords need an even address, words a multiple of four.
    function automatic logic is_misaligned(input size_e sz, input logic [1:0] off);
        logic mis;
        case (sz)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = off[0];
            default: mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-bus bundle between the memory-access stage (master) and memory (slave).
// Request side is held stable by the master until dbus_gnt; read data returns
// later with a single-cycle dbus_rvalid.
interface mem_access_if;
    import mem_access_pkg::*;

    logic            dbus_req;
    logic            dbus_we;
    logic [XLEN-1:0] dbus_addr;
    logic [XLEN-1:0] dbus_wdata;
    logic [3:0]      dbus_be;
    logic            dbus_gnt;
    logic            dbus_rvalid;
    logic [XLEN-1:0] dbus_rdata;

    modport master (
        output dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be,
        input  dbus_gnt, dbus_rvalid, dbus_rdata
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be,
        output dbus_gnt, dbus_rvalid, dbus_rdata
    );

endinterface

// File: rtl/mem_align.sv
// Byte-lane formatting: store byte enables / replicated write data, and load
// lane extraction with sign or zero extension.
// Purely combinational, no latency, no backpressure.
module mem_align
    import mem_access_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic            is_store,
    input  logic [1:0]      byte_off,
    input  logic [XLEN-1:0] st_data,
    input  logic [XLEN-1:0] ld_word,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] ld_data
);

    size_e           size;
    logic            is_signed;
    logic [XLEN-1:0] ld_shift;

    // Select lanes by access size; the addressed lane is shifted down to bit 0 for loads.
    always_comb begin
        size      = access_size(funct3, is_store);
        is_signed = !is_store && !funct3[2];
        ld_shift  = ld_word >> {byte_off, 3'b000};
        be        = 4'b1111;
        wdata     = st_data;
        ld_data   = ld_word;
        case (size)
            SZ_B: begin
                be      = 4'b0001 << byte_off;
                wdata   = {4{st_data[7:0]}};
                ld_data = {{(XLEN-8){is_signed & ld_shift[7]}}, ld_shift[7:0]};
            end
            SZ_H: begin
                be      = 4'b0011 << byte_off;
                wdata   = {2{st_data[15:0]}};
                ld_data = {{(XLEN-16){is_signed & ld_shift[15]}}, ld_shift[15:0]};
            end
            default: begin
                be      = 4'b1111;
                wdata   = st_data;
                ld_data = ld_word;
            end
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Pipeline memory-access stage: ALU ops pass through, loads/stores go to the data bus.
// Latency: ALU/misaligned 1 cycle, store >= 2, load >= 3 (more with gnt/rvalid delay).
// Backpressure: mem_stall holds upstream while a bus access is outstanding.
module mem_access
    import mem_access_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [XLEN-1:0]  in_result,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic             in_mem_read,
    input  logic             in_mem_write,
    input  logic [2:0]       in_funct3,
    input  logic [4:0]       in_rd,
    input  logic             in_reg_write,
    output logic             mem_stall,
    mem_access_if.master     dbus,
    output logic             wb_valid,
    output logic [XLEN-1:0]  wb_data,
    output logic [4:0]       wb_rd,
    output logic             wb_reg_write,
    output logic             misalign
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] sdata_q, sdata_d;
    logic [2:0]      f3_q, f3_d;
    logic            we_q, we_d;
    logic [4:0]      rd_q, rd_d;
    logic            rw_q, rw_d;

    logic            wb_valid_q, wb_valid_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic            wb_rw_q, wb_rw_d;
    logic            mis_q, mis_d;

    logic            is_mem;
    logic            in_req;
    logic [3:0]      al_be;
    logic [XLEN-1:0] al_wdata;
    logic [XLEN-1:0] al_ld_data;

    // Lane formatting always works from the latched access; loads read the live bus word.
    mem_align u_align (
        .funct3   (f3_q),
        .is_store (we_q),
        .byte_off (addr_q[1:0]),
        .st_data  (sdata_q),
        .ld_word  (dbus.dbus_rdata),
        .be       (al_be),
        .wdata    (al_wdata),
        .ld_data  (al_ld_data)
    );

    assign is_mem = in_mem_read | in_mem_write;
    assign in_req = (state_q == S_REQ);

    // Bus outputs are zero outside REQ so nothing leaks while idle or after reset.
    assign mem_stall        = (state_q != S_IDLE);
    assign dbus.dbus_req    = in_req;
    assign dbus.dbus_we     = in_req & we_q;
    assign dbus.dbus_addr   = in_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
    assign dbus.dbus_be     = in_req ? al_be : 4'b0000;
    assign dbus.dbus_wdata  = in_req ? al_wdata : '0;

    assign wb_valid     = wb_valid_q;
    assign wb_data      = wb_data_q;
    assign wb_rd        = wb_rd_q;
    assign wb_reg_write = wb_rw_q;
    assign misalign     = mis_q;

    // Next-state and writeback decode; writeback strobes default low so they pulse.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        sdata_d    = sdata_q;
        f3_d       = f3_q;
        we_d       = we_q;
        rd_d       = rd_q;
        rw_d       = rw_q;
        wb_valid_d = 1'b0;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        wb_rw_d    = 1'b0;
        mis_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (!is_mem) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = in_result;
                        wb_rd_d    = in_rd;
                        wb_rw_d    = in_reg_write && (in_rd != 5'd0);
                    end else if (is_misaligned(access_size(in_funct3, in_mem_write),
                                               in_result[1:0])) begin
                        // Faulting address goes out on wb_data; no bus traffic.
                        wb_valid_d = 1'b1;
                        mis_d      = 1'b1;
                        wb_data_d  = in_result;
                        wb_rd_d    = in_rd;
                    end else begin
                        // mem_write wins when both are set: the op is a store.
                        addr_d  = in_result;
                        sdata_d = in_rs2;
                        f3_d    = in_funct3;
                        we_d    = in_mem_write;
                        rd_d    = in_rd;
                        rw_d    = in_reg_write;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                // rvalid in this state belongs to nobody and is dropped.
                if (dbus.dbus_gnt) begin
                    if (we_q) begin
                        state_d    = S_IDLE;
                        wb_valid_d = 1'b1;
                        wb_data_d  = '0;
                        wb_rd_d    = rd_q;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (dbus.dbus_rvalid) begin
                    state_d    = S_IDLE;
                    wb_valid_d = 1'b1;
                    wb_data_d  = al_ld_data;
                    wb_rd_d    = rd_q;
                    wb_rw_d    = rw_q && (rd_q != 5'd0);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset abandons any pending access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            sdata_q    <= '0;
            f3_q       <= '0;
            we_q       <= 1'b0;
            rd_q       <= '0;
            rw_q       <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            wb_rw_q    <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            sdata_q    <= sdata_d;
            f3_q       <= f3_d;
            we_q       <= we_d;
            rd_q       <= rd_d;
            rw_q       <= rw_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            wb_rw_q    <= wb_rw_d;
            mis_q      <= mis_d;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed vector table, randomized transactions against a
// byte-arithmetic reference model, and hand sequences for stall and reset cases.
module tb_mem_access;
    import mem_access_pkg::*;

    localparam int K_ALU  = 0;
    localparam int K_LD   = 1;
    localparam int K_ST   = 2;
    localparam int K_BOTH = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_result;
    logic [31:0] in_rs2;
    logic        in_mem_read;
    logic        in_mem_write;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic        mem_stall;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic        misalign;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access_if bus();

    mem_access dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_result    (in_result),
        .in_rs2       (in_rs2),
        .in_mem_read  (in_mem_read),
        .in_mem_write (in_mem_write),
        .in_funct3    (in_funct3),
        .in_rd        (in_rd),
        .in_reg_write (in_reg_write),
        .mem_stall    (mem_stall),
        .dbus         (bus),
        .wb_valid     (wb_valid),
        .wb_data      (wb_data),
        .wb_rd        (wb_rd),
        .wb_reg_write (wb_reg_write),
        .misalign     (misalign)
    );

    typedef struct {
        int          kind;
        logic [2:0]  f3;
        logic [31:0] addr;      // in_result (address for memory ops)
        logic [31:0] rs2;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        rw;
        int          gnt_dly;
        int          rv_wait;
        bit          same;      // rvalid also asserted on the gnt cycle
        bit          exp_mis;
        bit          chk_data;
        logic [31:0] exp_data;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic        exp_rw;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: expected results from byte arithmetic on the access width.
    function automatic vec_t model(input vec_t v);
        vec_t        r;
        int          n;
        int          off;
        bit          st;
        bit          sgn;
        logic [63:0] val;
        r   = v;
        st  = (v.kind == K_ST) || (v.kind == K_BOTH);
        off = int'(v.addr % 4);
        if (st) n = (v.f3 == 3'd0) ? 1 : (v.f3 == 3'd1) ? 2 : 4;
        else    n = (v.f3 == 3'd0 || v.f3 == 3'd4) ? 1 : (v.f3 == 3'd1 || v.f3 == 3'd5) ? 2 : 4;
        sgn = !st && (v.f3 == 3'd0 || v.f3 == 3'd1);
        r.exp_mis   = (v.kind != K_ALU) && ((off % n) != 0);
        r.exp_be    = 4'(((1 << n) - 1) << off);
        r.exp_wdata = (n == 1) ? {24'd0, v.rs2[7:0]} * 32'h01010101 :
                      (n == 2) ? {16'd0, v.rs2[15:0]} * 32'h00010001 : v.rs2;
        r.chk_data  = 1'b1;
        r.exp_rw    = 1'b0;
        r.exp_data  = '0;
        if (v.kind == K_ALU) begin
            r.exp_data = v.addr;
            r.exp_rw   = v.rw && (v.rd != 5'd0);
        end else if (r.exp_mis) begin
            r.exp_data = v.addr;
        end else if (st) begin
            r.chk_data = 1'b0;
        end else begin
            val = (64'(v.rdata) >> (8 * off)) & ((64'd1 << (8 * n)) - 64'd1);
            if (sgn && val[8 * n - 1]) val = val - (64'd1 << (8 * n));
            r.exp_data = val[31:0];
            r.exp_rw   = v.rw && (v.rd != 5'd0);
        end
        return r;
    endfunction

    // Drive one transaction from an idle DUT and check every observable step.
    task automatic run(input vec_t v, input string p);
        bit          st;
        logic [31:0] a;
        st = (v.kind == K_ST) || (v.kind == K_BOTH);
        a  = {v.addr[31:2], 2'b00};
        in_valid     = 1'b1;
        in_result    = v.addr;
        in_rs2       = v.rs2;
        in_mem_read  = (v.kind == K_LD) || (v.kind == K_BOTH);
        in_mem_write = st;
        in_funct3    = v.f3;
        in_rd        = v.rd;
        in_reg_write = v.rw;
        tick();
        in_valid     = 1'b0;
        in_result    = $urandom;
        in_rs2       = $urandom;
        in_funct3    = 3'($urandom_range(0, 7));
        in_rd        = 5'($urandom_range(0, 31));
        if (v.kind == K_ALU || v.exp_mis) begin
            chk({p, "_wb_valid"}, 32'(wb_valid), 32'd1);
            chk({p, "_misalign"}, 32'(misalign), 32'(v.exp_mis));
            chk({p, "_no_req"}, 32'(bus.dbus_req), 32'd0);
            chk({p, "_wb_data"}, wb_data, v.exp_data);
            chk({p, "_wb_rd"}, 32'(wb_rd), 32'(v.rd));
            chk({p, "_wb_rw"}, 32'(wb_reg_write), 32'(v.exp_rw));
            chk({p, "_stall"}, 32'(mem_stall), 32'd0);
        end else begin
            chk({p, "_req_wbv"}, 32'(wb_valid), 32'd0);
            chk({p, "_req"}, 32'(bus.dbus_req), 32'd1);
            chk({p, "_req_stall"}, 32'(mem_stall), 32'd1);
            chk({p, "_addr"}, bus.dbus_addr, a);
            chk({p, "_we"}, 32'(bus.dbus_we), 32'(st));
            if (st) begin
                chk({p, "_be"}, 32'(bus.dbus_be), 32'(v.exp_be));
                chk({p, "_wdata"}, bus.dbus_wdata, v.exp_wdata);
            end
            for (int i = 0; i < v.gnt_dly; i++) begin
                tick();
                chk({p, "_hold_req"}, 32'(bus.dbus_req), 32'd1);
                chk({p, "_hold_addr"}, bus.dbus_addr, a);
                chk({p, "_hold_wbv"}, 32'(wb_valid), 32'd0);
            end
            bus.dbus_gnt = 1'b1;
            if (v.same) begin
                bus.dbus_rvalid = 1'b1;
                bus.dbus_rdata  = ~v.rdata;
            end
            tick();
            bus.dbus_gnt    = 1'b0;
            bus.dbus_rvalid = 1'b0;
            if (st) begin
                chk({p, "_st_wbv"}, 32'(wb_valid), 32'd1);
                chk({p, "_st_rw"}, 32'(wb_reg_write), 32'd0);
                chk({p, "_st_rd"}, 32'(wb_rd), 32'(v.rd));
                chk({p, "_st_mis"}, 32'(misalign), 32'd0);
                chk({p, "_st_req"}, 32'(bus.dbus_req), 32'd0);
                chk({p, "_st_stall"}, 32'(mem_stall), 32'd0);
            end else begin
                chk({p, "_wait_wbv"}, 32'(wb_valid), 32'd0);
                chk({p, "_wait_req"}, 32'(bus.dbus_req), 32'd0);
                chk({p, "_wait_stall"}, 32'(mem_stall), 32'd1);
                for (int i = 0; i < v.rv_wait; i++) begin
                    bus.dbus_rdata = $urandom;
                    tick();
                    chk({p, "_rvw_wbv"}, 32'(wb_valid), 32'd0);
                end
                bus.dbus_rvalid = 1'b1;
                bus.dbus_rdata  = v.rdata;
                tick();
                bus.dbus_rvalid = 1'b0;
                bus.dbus_rdata  = $urandom;
                chk({p, "_ld_wbv"}, 32'(wb_valid), 32'd1);
                chk({p, "_ld_data"}, wb_data, v.exp_data);
                chk({p, "_ld_rd"}, 32'(wb_rd), 32'(v.rd));
                chk({p, "_ld_rw"}, 32'(wb_reg_write), 32'(v.exp_rw));
                chk({p, "_ld_mis"}, 32'(misalign), 32'd0);
                chk({p, "_ld_stall"}, 32'(mem_stall), 32'd0);
            end
        end
        tick();
        chk({p, "_pulse_wbv"}, 32'(wb_valid), 32'd0);
        chk({p, "_pulse_mis"}, 32'(misalign), 32'd0);
    endtask

    vec_t tbl[$];
    vec_t rv;

    initial begin
        // kind, f3, addr, rs2, rdata, rd, rw, gnt_dly, rv_wait, same, mis, chk, data, be, wdata, rw
        tbl.push_back('{K_ALU,  3'd0, 32'h12345678, 32'h0, 32'h0, 5'd5, 1'b1, 0, 0, 0, 0, 1, 32'h12345678, 4'h0, 32'h0, 1'b1});
        tbl.push_back('{K_ALU,  3'd0, 32'hCAFEBABE, 32'h0, 32'h0, 5'd0, 1'b1, 0, 0, 0, 0, 1, 32'hCAFEBABE, 4'h0, 32'h0, 1'b0});
        tbl.push_back('{K_ALU,  3'd2, 32'h0BADF00D, 32'h0, 32'h0, 5'd9, 1'b0, 0, 0, 0, 0, 1, 32'h0BADF00D, 4'h0, 32'h0, 1'b0});
        tbl.push_back('{K_ST,   3'd0, 32'h00001003, 32'h000000A5, 32'h0, 5'd4, 1'b1, 0, 0, 0, 0, 0, 32'h0, 4'h8, 32'hA5A5A5A5, 1'b0});
        tbl.push_back('{K_LD,   3'd0, 32'h00002002, 32'h0, 32'h00800000, 5'd7, 1'b1, 0, 2, 0, 0, 1, 32'hFFFFFF80, 4'h0, 32'h0, 1'b1});
        tbl.push_back('{K_LD,   3'd4, 32'h00002002, 32'h0, 32'h00800000, 5'd7, 1'b1, 0, 2, 0, 0, 1, 32'h00000080, 4'h0, 32'h0, 1'b1});
        tbl.push_back('{K_LD,   3'd2, 32'h00003002, 32'h0, 32'h0, 5'd8, 1'b1, 0, 0, 0, 1, 1, 32'h00003002, 4'h0, 32'h0, 1'b0});
        tbl.push_back('{K_ST,   3'd1, 32'h00004002, 32'h1234BEEF, 32'h0, 5'd2, 1'b1, 1, 0, 0, 0, 0, 32'h0, 4'hC, 32'hBEEFBEEF, 1'b0});
        tbl.push_back('{K_ST,   3'd2, 32'h00005000, 32'hCAFEF00D, 32'h0, 5'd2, 1'b0, 2, 0, 0, 0, 0, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0});
        tbl.push_back('{K_LD,   3'd1, 32'h00006002, 32'h0, 32'h80011234, 5'd3, 1'b1, 0, 0, 0, 0, 1, 32'hFFFF8001, 4'h0, 32'h0, 1'b1});
        tbl.push_back('{K_LD,   3'd5, 32'h00006000, 32'h0, 32'h80019234, 5'd3, 1'b1, 0, 0, 0, 0, 1, 32'h00009234, 4'h0, 32'h0, 1'b1});
        tbl.push_back('{K_LD,   3'd2, 32'h00007000, 32'h0, 32'hDEADBEEF, 5'd10, 1'b1, 1, 1, 1, 0, 1, 32'hDEADBEEF, 4'h0, 32'h0, 1'b1});
        tbl.push_back('{K_ST,   3'd1, 32'h00004001, 32'h11111111, 32'h0, 5'd2, 1'b1, 0, 0, 0, 1, 1, 32'h00004001, 4'h0, 32'h0, 1'b0});
        tbl.push_back('{K_LD,   3'd3, 32'h00008004, 32'h0, 32'h11223344, 5'd12, 1'b1, 0, 0, 0, 0, 1, 32'h11223344, 4'h0, 32'h0, 1'b1});
        tbl.push_back('{K_LD,   3'd7, 32'h00008006, 32'h0, 32'h0, 5'd12, 1'b1, 0, 0, 0, 1, 1, 32'h00008006, 4'h0, 32'h0, 1'b0});
        tbl.push_back('{K_LD,   3'd6, 32'h0000B003, 32'h0, 32'h0, 5'd13, 1'b1, 0, 0, 0, 1, 1, 32'h0000B003, 4'h0, 32'h0, 1'b0});
        tbl.push_back('{K_BOTH, 3'd0, 32'h00009001, 32'h0000005A, 32'h0, 5'd6, 1'b1, 0, 0, 0, 0, 0, 32'h0, 4'h2, 32'h5A5A5A5A, 1'b0});
        tbl.push_back('{K_ST,   3'd4, 32'h0000A000, 32'h01020304, 32'h0, 5'd6, 1'b1, 0, 0, 0, 0, 0, 32'h0, 4'hF, 32'h01020304, 1'b0});
        tbl.push_back('{K_LD,   3'd0, 32'h0000B001, 32'h0, 32'h00007F00, 5'd0, 1'b1, 0, 1, 0, 0, 1, 32'h0000007F, 4'h0, 32'h0, 1'b0});

        rst             = 1'b1;
        in_valid        = 1'b0;
        in_result       = '0;
        in_rs2          = '0;
        in_mem_read     = 1'b0;
        in_mem_write    = 1'b0;
        in_funct3       = '0;
        in_rd           = '0;
        in_reg_write    = 1'b0;
        bus.dbus_gnt    = 1'b0;
        bus.dbus_rvalid = 1'b0;
        bus.dbus_rdata  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_req", 32'(bus.dbus_req), 32'd0);
        chk("rst_wbv", 32'(wb_valid), 32'd0);
        chk("rst_mis", 32'(misalign), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_be", 32'(bus.dbus_be), 32'd0);

        // First op accepted on the first edge after reset release
        rst          = 1'b0;
        in_valid     = 1'b1;
        in_result    = 32'h00000055;
        in_rd        = 5'd1;
        in_reg_write = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("first_accept_wbv", 32'(wb_valid), 32'd1);
        chk("first_accept_data", wb_data, 32'h00000055);
        tick();

        // Directed vector table
        foreach (tbl[i]) run(tbl[i], $sformatf("v%0d", i));

        // Randomized transactions against the reference model
        for (int i = 0; i < 80; i++) begin
            rv.kind    = $urandom_range(0, 3);
            rv.f3      = 3'($urandom_range(0, 7));
            rv.addr    = $urandom;
            rv.rs2     = $urandom;
            rv.rdata   = $urandom;
            rv.rd      = 5'($urandom_range(0, 31));
            rv.rw      = 1'($urandom_range(0, 1));
            rv.gnt_dly = $urandom_range(0, 3);
            rv.rv_wait = $urandom_range(0, 3);
            rv.same    = 1'($urandom_range(0, 1));
            rv = model(rv);
            run(rv, $sformatf("r%0d", i));
        end

        // Grant withheld five cycles while a new op waits upstream
        in_valid     = 1'b1;
        in_result    = 32'h0000C002;
        in_rs2       = 32'h0000ABCD;
        in_mem_read  = 1'b0;
        in_mem_write = 1'b1;
        in_funct3    = 3'd1;
        in_rd        = 5'd4;
        in_reg_write = 1'b1;
        tick();
        in_result    = 32'hDEAD0000;
        in_mem_write = 1'b0;
        in_rd        = 5'd9;
        for (int i = 0; i < 6; i++) begin
            chk("stall_req", 32'(bus.dbus_req), 32'd1);
            chk("stall_addr", bus.dbus_addr, 32'h0000C000);
            chk("stall_be", 32'(bus.dbus_be), 32'hC);
            chk("stall_wdata", bus.dbus_wdata, 32'hABCDABCD);
            chk("stall_stall", 32'(mem_stall), 32'd1);
            chk("stall_wbv", 32'(wb_valid), 32'd0);
            if (i < 5) tick();
        end
        bus.dbus_gnt = 1'b1;
        in_valid     = 1'b0;
        tick();
        bus.dbus_gnt = 1'b0;
        chk("stall_done_wbv", 32'(wb_valid), 32'd1);
        chk("stall_done_rd", 32'(wb_rd), 32'd4);
        chk("stall_done_rw", 32'(wb_reg_write), 32'd0);
        tick();
        chk("stall_no_extra_wbv", 32'(wb_valid), 32'd0);

        // Reset while requesting: bus request drops at once
        in_valid     = 1'b1;
        in_result    = 32'h0000E000;
        in_mem_write = 1'b1;
        in_funct3    = 3'd2;
        tick();
        in_valid     = 1'b0;
        in_mem_write = 1'b0;
        chk("rreq_req_before", 32'(bus.dbus_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rreq_req", 32'(bus.dbus_req), 32'd0);
        chk("rreq_stall", 32'(mem_stall), 32'd0);
        chk("rreq_addr", bus.dbus_addr, 32'd0);
        @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.dbus_gnt = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rreq_after_wbv", 32'(wb_valid), 32'd0);
            chk("rreq_after_req", 32'(bus.dbus_req), 32'd0);
        end
        bus.dbus_gnt = 1'b0;

        // Reset while waiting for read data: late rvalid produces nothing
        in_valid     = 1'b1;
        in_result    = 32'h0000D000;
        in_mem_read  = 1'b1;
        in_funct3    = 3'd2;
        in_rd        = 5'd11;
        in_reg_write = 1'b1;
        tick();
        in_valid     = 1'b0;
        in_mem_read  = 1'b0;
        bus.dbus_gnt = 1'b1;
        tick();
        bus.dbus_gnt = 1'b0;
        chk("rwait_in_wait", 32'(mem_stall), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rwait_req", 32'(bus.dbus_req), 32'd0);
        chk("rwait_stall", 32'(mem_stall), 32'd0);
        chk("rwait_wbv", 32'(wb_valid), 32'd0);
        chk("rwait_wb_data", wb_data, 32'd0);
        @(posedge clk);
        #1;
        rst             = 1'b0;
        bus.dbus_rvalid = 1'b1;
        bus.dbus_rdata  = 32'h13579BDF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rwait_late_wbv", 32'(wb_valid), 32'd0);
            chk("rwait_late_stall", 32'(mem_stall), 32'd0);
        end
        bus.dbus_rvalid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 in_valid  in  1  EX/MEM slot holds an instruction.
REQ-004 in_result  in  XLEN  ALU result; effective address for load/store.
REQ-005 in_rs2  in  XLEN  store data.
REQ-006 in_mem_read  in  1  load.
REQ-007 in_mem_write  in  1  store.
REQ-008 in_funct3  in  3  RV32I load/store funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-009 in_rd  in  5  destination register.
REQ-010 in_reg_write  in  1  writeback enable.
REQ-011 mem_stall  out  1  upstream hold; high whenever state != IDLE.
REQ-012 dbus_req  out  1  data-bus request.
REQ-013 dbus_we  out  1  1 = write.
REQ-014 dbus_addr  out  XLEN  word-aligned address (bits [1:0] = 0).
REQ-015 dbus_wdata  out  XLEN  lane-replicated store data.
REQ-016 dbus_be  out  4  byte enables.
REQ-017 dbus_gnt  in  1  request accepted this cycle.
REQ-018 dbus_rvalid  in  1  read data valid.
REQ-019 dbus_rdata  in  XLEN  read data word.
REQ-020 wb_valid  out  1  one-cycle pulse; result presented to WB.
REQ-021 wb_data  out  XLEN  writeback value.
REQ-022 wb_rd  out  5  destination register.
REQ-023 wb_reg_write  out  1  write enable; forced 0 when wb_rd = 0.
REQ-024 misalign  out  1  one-cycle pulse; misaligned access, wb_data holds faulting address.

Function
REQ-025 FSM states IDLE, REQ, WAIT; the input is accepted only when in_valid and state = IDLE.
REQ-026 Non-memory op accepted: next cycle wb_valid=1, wb_data=in_result, wb_rd/wb_reg_write from inputs; state stays IDLE (latency 1).
REQ-027 Aligned memory op accepted: latch address, data, funct3, rd, reg_write; go to REQ.
REQ-028 REQ: dbus_req=1; addr/we/be/wdata held stable until dbus_gnt; store on gnt -> IDLE with wb_valid=1, wb_reg_write=0 next cycle (minimum latency 2).
REQ-029 Load on gnt -> WAIT; on dbus_rvalid in WAIT: next cycle wb_valid=1 with extended data, -> IDLE (minimum latency 3).
REQ-030 dbus_rvalid outside WAIT is ignored; gnt and rvalid in the same REQ cycle: gnt honoured, rvalid ignored.
REQ-031 Store lanes: SB be=4'b0001<<addr[1:0], byte replicated x4; SH be=4'b0011<<addr[1:0], halfword replicated x2; SW be=4'b1111.
REQ-032 Load extract: lane selected by addr[1:0]; LB/LH sign-extended, LBU/LHU zero-extended, LW passed through.
REQ-033 Misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0): no bus request; next cycle misalign=1, wb_valid=1, wb_reg_write=0, wb_data=address; state stays IDLE.
REQ-034 mem_read and mem_write both high: performed as a store.
REQ-035 Outputs registered except mem_stall and the dbus_* signals, which decode from state and latched registers.
REQ-036 Undefined funct3 on a memory op: treated as word access.

Reset
REQ-037 rst forces state=IDLE, dbus_req=0, wb_valid=0, misalign=0 and all data outputs to 0 immediately, including mid-transaction; the pending access is abandoned and no writeback occurs.
REQ-038 The first input is accepted on the first rising edge after rst deasserts.

Structure
REQ-039 XLEN, funct3 load/store codes and FSM state encodings reside in the shared defines file.
REQ-040 Lane formatting and load extraction reside in one combinational sub-module, mem_align.

Verification
REQ-041 SB addr 0x1003, rs2 0x000000A5, gnt at first REQ cycle -> dbus_be=4'b1000, wdata=0xA5A5A5A5, addr=0x1000, wb_valid 2 cycles after accept.
REQ-042 LB addr 0x2002, rdata 0x0080_0000, rvalid 3 cycles after gnt -> wb_data=0xFFFFFF80; LBU on the same access -> 0x00000080.
REQ-043 LW addr 0x3002 -> no dbus_req, misalign=1, wb_data=0x00003002, wb_reg_write=0.
REQ-044 gnt withheld 5 cycles -> dbus_req/addr/be stable throughout, mem_stall=1, new in_valid not accepted.
REQ-045 rst asserted in WAIT -> dbus_req=0, state IDLE, no wb_valid when rvalid arrives later.
